sd_cmd_model: RTL and testbench

Behavioural SD-card command-line endpoint for the SDIO card model. It sits between the card's command FSM and the bidirectional `sd_cmd` pin. It deserialises 48-bit host commands, checks CRC7 and reports them. It also serialises card replies (48-bit or 136-bit), either push-pull or open-drain, and detects arbitration collisions on the shared line.

---
 rtl/sd_cmd_model.sv | 188 ++++++++++++++++++
 tb/tb_sd_cmd_model.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_model.sv
// SD card command-line endpoint: deserialises CRC7-checked 48-bit host commands and serialises
// 48/136-bit replies (push-pull or open-drain). Define SDCMD_COLLISION_EN for open-drain arbitration abort.
module sd_cmd_model (
  input  logic         sd_clk,
  input  logic         rst_n,
  inout  wire          sd_cmd,
  output logic         sd_ds,
  output logic         o_cmd_valid,
  output logic [5:0]   o_cmd,
  output logic [31:0]  o_arg,
  output logic         o_crc_err,
  input  logic         i_valid,
  input  logic         i_type,
  output logic         o_busy,
  input  logic [5:0]   i_reply,
  input  logic [119:0] i_arg,
  input  logic         i_use_crc,
  input  logic         i_drive,
  output logic         o_collision
);

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  logic line;
  assign line = sd_cmd;

  typedef enum logic [2:0] {RX_IDLE, RX_HDR, RX_BODY, RX_END, RX_SKIP} rx_state_t;
  rx_state_t rx_state, rx_next;

  logic [5:0]  rx_cnt;
  logic [37:0] rx_sh;
  logic [6:0]  rx_crc;
  logic [6:0]  rx_rcrc;
  logic        rx_cnt_en, rx_data_en, rx_crc_en, rx_done;

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // Our own reply pulls the line low, so a start bit is only honoured while no reply is active
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (!line && !o_busy) rx_next = RX_HDR;
      RX_HDR:  rx_next = line ? RX_BODY : RX_SKIP;
      RX_BODY: if (rx_cnt == 6'd44) rx_next = RX_END;
      RX_SKIP: if (rx_cnt == 6'd45) rx_next = RX_IDLE;
      RX_END:  rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_en  = (rx_state == RX_BODY) || (rx_state == RX_SKIP);
    rx_data_en = (rx_state == RX_BODY) && (rx_cnt < 6'd38);
    rx_crc_en  = (rx_state == RX_BODY) && (rx_cnt >= 6'd38);
    rx_done    = (rx_state == RX_END);
  end

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt  <= 6'd0;
      rx_sh   <= 38'd0;
      rx_crc  <= 7'd0;
      rx_rcrc <= 7'd0;
    end else begin
      rx_cnt <= rx_cnt_en ? rx_cnt + 6'd1 : 6'd0;
      if (rx_state == RX_HDR) begin
        rx_crc <= crc7_step(7'd0, line);
      end else if (rx_data_en) begin
        rx_crc <= crc7_step(rx_crc, line);
        rx_sh  <= {rx_sh[36:0], line};
      end
      if (rx_crc_en) rx_rcrc <= {rx_rcrc[5:0], line};
    end
  end

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cmd_valid <= 1'b0;
      o_crc_err   <= 1'b0;
      o_cmd       <= 6'd0;
      o_arg       <= 32'd0;
    end else begin
      o_cmd_valid <= rx_done;
      if (rx_done) begin
        o_cmd     <= rx_sh[37:32];
        o_arg     <= rx_sh[31:0];
        o_crc_err <= (rx_rcrc != rx_crc) || !line;
      end
    end
  end

  logic         lat_type, lat_use_crc, lat_drive;
  logic [5:0]   lat_reply;
  logic [119:0] lat_arg;
  logic         coll_q, coll_hit;
  logic         tx_on, tx_fin, tx_bit, drive_en;
  logic [7:0]   tx_cnt, data_end, crc_end;
  logic [125:0] tx_sh;
  logic [6:0]   tx_crc;

  // data_end: first CRC bit index; crc_end: end-bit index
  assign data_end = lat_type ? 8'd128 : 8'd40;
  assign crc_end  = lat_type ? 8'd135 : 8'd47;

`ifdef SDCMD_COLLISION_EN
  assign coll_hit = tx_on && !lat_drive && tx_bit && !coll_q && !line;
`else
  assign coll_hit = 1'b0;
`endif

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_busy      <= 1'b0;
      coll_q      <= 1'b0;
      lat_type    <= 1'b0;
      lat_use_crc <= 1'b0;
      lat_drive   <= 1'b0;
      lat_reply   <= 6'd0;
      lat_arg     <= 120'd0;
    end else if (i_valid && !o_busy) begin
      o_busy      <= 1'b1;
      coll_q      <= 1'b0;
      lat_type    <= i_type;
      lat_use_crc <= i_use_crc;
      lat_drive   <= i_drive;
      lat_reply   <= i_reply;
      lat_arg     <= i_arg;
    end else if (o_busy) begin
      if (tx_fin || coll_q) o_busy <= 1'b0;
      if (coll_hit)         coll_q <= 1'b1;
    end
  end

  // Reply bits change on falling edges; tx_cnt is the index of the bit driven at the next one
  always_ff @(negedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_on  <= 1'b0;
      tx_fin <= 1'b0;
      tx_bit <= 1'b1;
      tx_cnt <= 8'd0;
      tx_sh  <= 126'd0;
      tx_crc <= 7'd0;
    end else if (!o_busy) begin
      tx_on  <= 1'b0;
      tx_fin <= 1'b0;
      tx_bit <= 1'b1;
      tx_cnt <= 8'd0;
    end else if (!tx_on && !tx_fin) begin
      tx_on  <= 1'b1;
      tx_bit <= 1'b0;
      tx_cnt <= 8'd1;
      tx_crc <= 7'd0;
      tx_sh  <= lat_type ? {lat_reply, lat_arg} : {lat_reply, lat_arg[31:0], 88'd0};
    end else if (tx_on) begin
      tx_cnt <= tx_cnt + 8'd1;
      if (tx_cnt == crc_end + 8'd1) begin
        tx_on  <= 1'b0;
        tx_fin <= 1'b1;
        tx_bit <= 1'b1;
      end else if (tx_cnt == crc_end) begin
        tx_bit <= 1'b1;
      end else if (tx_cnt >= data_end) begin
        tx_bit <= lat_use_crc ? tx_crc[6] : 1'b1;
        tx_crc <= {tx_crc[5:0], 1'b0};
      end else if (tx_cnt >= 8'd2) begin
        tx_bit <= tx_sh[125];
        tx_sh  <= {tx_sh[124:0], 1'b0};
        // long replies protect only the payload, not the header
        if (!lat_type || tx_cnt >= 8'd8) tx_crc <= crc7_step(tx_crc, tx_sh[125]);
      end else begin
        tx_bit <= 1'b0;
      end
    end
  end

  assign drive_en    = tx_on && !coll_q && (lat_drive || !tx_bit);
  assign sd_cmd      = drive_en ? tx_bit : 1'bz;
  assign sd_ds       = sd_clk & tx_on & !coll_q;
  assign o_collision = coll_q;

endmodule

// File: tb/tb_sd_cmd_model.sv
// Directed bench for sd_cmd_model: table of host command frames plus hand-written reply,
// open-drain, collision and reset sequences.
module tb_sd_cmd_model;

  logic         sd_clk = 1'b0;
  logic         rst_n;
  logic         host_oe, host_bit;
  wire          sd_cmd;
  logic         sd_ds, o_cmd_valid, o_crc_err, o_busy, o_collision;
  logic [5:0]   o_cmd;
  logic [31:0]  o_arg;
  logic         i_valid, i_type, i_use_crc, i_drive;
  logic [5:0]   i_reply;
  logic [119:0] i_arg;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;

  pullup (sd_cmd);
  assign sd_cmd = host_oe ? host_bit : 1'bz;

  always #5 sd_clk = ~sd_clk;

  sd_cmd_model dut (
    .sd_clk(sd_clk), .rst_n(rst_n), .sd_cmd(sd_cmd), .sd_ds(sd_ds),
    .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_arg(o_arg), .o_crc_err(o_crc_err),
    .i_valid(i_valid), .i_type(i_type), .o_busy(o_busy), .i_reply(i_reply),
    .i_arg(i_arg), .i_use_crc(i_use_crc), .i_drive(i_drive), .o_collision(o_collision)
  );

  always @(negedge sd_clk) if (o_cmd_valid === 1'b1) n_valid++;

  typedef struct {
    logic [47:0] frame;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        err;
  } cmd_vec_t;

  cmd_vec_t vecs [6];

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [95:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sd_clk);
      host_oe  = 1'b1;
      host_bit = bits[95-i];
    end
  endtask

  task automatic send_cmd_check(input string name, input logic [47:0] frame,
                                input logic [5:0] cmd, input logic [31:0] arg, input logic err);
    send_bits({frame, 48'd0}, 48);
    @(negedge sd_clk);
    host_oe = 1'b0;
    chk({name, "_vld"}, o_cmd_valid, 1'b1);
    chk({name, "_cmd"}, o_cmd, cmd);
    chk({name, "_arg"}, o_arg, arg);
    chk({name, "_err"}, o_crc_err, err);
    @(negedge sd_clk);
    chk({name, "_pulse"}, o_cmd_valid, 1'b0);
  endtask

  // force_k: reply bit index during which the host pulls the line low
  // poke_k: reply bit index during which a conflicting request is presented
  task automatic do_reply(input logic typ, input logic [5:0] rep, input logic [119:0] arg,
                          input logic use_crc, input logic drv, input int force_k, input int poke_k,
                          output logic [139:0] cap, output int busy_cnt, output int ds_cnt,
                          output logic last_bit);
    int k;
    cap = '0; busy_cnt = 0; ds_cnt = 0; k = 0; last_bit = 1'b0;
    @(negedge sd_clk);
    i_valid = 1'b1; i_type = typ; i_reply = rep; i_arg = arg; i_use_crc = use_crc; i_drive = drv;
    @(posedge sd_clk); #1;
    i_valid = 1'b0;
    while (o_busy && busy_cnt < 300) begin
      busy_cnt++;
      @(negedge sd_clk);
      host_oe  = (k == force_k);
      host_bit = 1'b0;
      i_valid  = (k == poke_k);
      if (k == poke_k) begin
        i_type = ~typ; i_reply = ~rep; i_arg = ~arg; i_use_crc = ~use_crc;
      end
      @(posedge sd_clk); #1;
      cap = {cap[138:0], sd_cmd};
      if (sd_ds) ds_cnt++;
      last_bit = sd_cmd;
      k++;
    end
    host_oe = 1'b0;
    i_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [139:0] cap;
    logic [119:0] a136;
    logic [135:0] exp136;
    int           bc, dc;
    logic         lb;

    vecs[0] = '{48'h40_00000000_95, 6'd0,  32'h0,     1'b0};
    vecs[1] = '{48'h48_000001AA_87, 6'd8,  32'h1AA,   1'b0};
    vecs[2] = '{48'h48_000001AA_85, 6'd8,  32'h1AA,   1'b1};
    vecs[3] = '{48'h40_00000000_94, 6'd0,  32'h0,     1'b1};
    vecs[4] = '{48'h51_00000000_55, 6'd17, 32'h0,     1'b0};
    vecs[5] = '{48'h77_00000000_65, 6'd55, 32'h0,     1'b0};

    rst_n = 1'b0; host_oe = 1'b0; host_bit = 1'b1;
    i_valid = 1'b0; i_type = 1'b0; i_reply = 6'd0; i_arg = '0; i_use_crc = 1'b0; i_drive = 1'b0;
    #12;
    chk("reset_outs", {o_cmd_valid, o_crc_err, o_busy, o_collision, sd_ds, o_cmd, o_arg}, '0);
    chk("reset_line", sd_cmd, 1'b1);
    @(negedge sd_clk); rst_n = 1'b1;
    repeat (3) @(negedge sd_clk);

    for (int v = 0; v < 6; v++) begin
      send_cmd_check($sformatf("cmd%0d", v), vecs[v].frame, vecs[v].cmd, vecs[v].arg, vecs[v].err);
      repeat (2) @(negedge sd_clk);
    end

    // transmission bit 0 frame is skipped; a command directly behind it still decodes
    send_bits({48'h00_12345678_FF, 48'h48_000001AA_87}, 96);
    @(negedge sd_clk); host_oe = 1'b0;
    chk("skip_vld", o_cmd_valid, 1'b1);
    chk("skip_cmd", o_cmd, 6'd8);
    chk("skip_arg", o_arg, 32'h1AA);
    chk("skip_err", o_crc_err, 1'b0);
    repeat (2) @(negedge sd_clk);

    // push-pull 48-bit reply, CRC7 of 0x1100000000 is 0x60; conflicting request mid-frame
    do_reply(1'b0, 6'd17, 120'd0, 1'b1, 1'b1, -1, 20, cap, bc, dc, lb);
    chk("r48_frame", cap[48:1], 48'h11_00000000_C1);
    chk("r48_busy", bc, 49);
    chk("r48_ds", dc, 48);
    repeat (2) @(negedge sd_clk);

    do_reply(1'b0, 6'h2A, 120'hDEADBEEF, 1'b0, 1'b1, -1, -1, cap, bc, dc, lb);
    chk("r48_nocrc_frame", cap[48:1], 48'h2A_DEADBEEF_FF);
    chk("r48_nocrc_busy", bc, 49);
    repeat (2) @(negedge sd_clk);

    // 136-bit reply: payload bits 119, 64, 0 -> CRC7 = x^126 ^ x^71 ^ x^7 = 0x70
    a136 = '0; a136[119] = 1'b1; a136[64] = 1'b1; a136[0] = 1'b1;
    exp136 = {2'b00, 6'h3F, a136, 7'h70, 1'b1};
    do_reply(1'b1, 6'd63, a136, 1'b1, 1'b1, -1, -1, cap, bc, dc, lb);
    chk("r136_frame", cap[136:1], exp136);
    chk("r136_busy", bc, 137);
    chk("r136_ds", dc, 136);
    repeat (2) @(negedge sd_clk);

    do_reply(1'b0, 6'd17, 120'd0, 1'b1, 1'b0, -1, -1, cap, bc, dc, lb);
    chk("od_frame", cap[48:1], 48'h11_00000000_C1);
    chk("od_busy", bc, 49);
    repeat (2) @(negedge sd_clk);

    // host pulls low during released bit 3 of an open-drain reply
    do_reply(1'b0, 6'd17, 120'd0, 1'b1, 1'b0, 3, -1, cap, bc, dc, lb);
`ifdef SDCMD_COLLISION_EN
    chk("coll_flag", o_collision, 1'b1);
    chk("coll_busy", bc, 5);
    chk("coll_release", lb, 1'b1);
`else
    chk("coll_flag", o_collision, 1'b0);
    chk("coll_busy", bc, 49);
    chk("coll_frame", cap[48:1], 48'h01_00000000_C1);
`endif
    repeat (2) @(negedge sd_clk);

    do_reply(1'b0, 6'd17, 120'd0, 1'b1, 1'b1, -1, -1, cap, bc, dc, lb);
    chk("post_coll_flag", o_collision, 1'b0);
    chk("post_coll_frame", cap[48:1], 48'h11_00000000_C1);
    repeat (2) @(negedge sd_clk);

    // reset in the middle of a push-pull reply while it drives a 0
    @(negedge sd_clk);
    i_valid = 1'b1; i_type = 1'b0; i_reply = 6'd17; i_arg = '0; i_use_crc = 1'b1; i_drive = 1'b1;
    @(posedge sd_clk); #1;
    i_valid = 1'b0;
    repeat (12) @(posedge sd_clk);
    #1;
    chk("mid_line_low", sd_cmd, 1'b0);
    chk("mid_busy", o_busy, 1'b1);
    #2; rst_n = 1'b0; #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_release", sd_cmd, 1'b1);
    chk("rst_ds", sd_ds, 1'b0);
    @(negedge sd_clk); rst_n = 1'b1;
    repeat (2) @(negedge sd_clk);
    send_cmd_check("post_rst", 48'h51_00000000_55, 6'd17, 32'h0, 1'b0);
    repeat (2) @(negedge sd_clk);

    chk("valid_pulse_total", n_valid, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
